// File: rtl/svc_rv_stage_if_mem.sv
// Instruction fetch stage for fixed-latency instruction memories. Sideband rides a
// matched-latency pipe; a credit-gated response FIFO absorbs returns during stalls.
module svc_rv_stage_if_mem #(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 1,
  parameter int FIFO_DEPTH  = MEM_LATENCY + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  output logic            fetch_fire,
  input  logic            if_id_stall,
  input  logic            if_id_flush,
  input  logic            btb_hit_if,
  input  logic            btb_pred_taken_if,
  input  logic [XLEN-1:0] btb_target_if,
  input  logic            ras_valid_if,
  input  logic [XLEN-1:0] ras_target_if,
  output logic            imem_ren,
  output logic [31:0]     imem_raddr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_id,
  output logic            valid_id,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc_plus4_id,
  output logic            btb_hit_id,
  output logic            btb_pred_taken_id,
  output logic [XLEN-1:0] btb_target_id,
  output logic            ras_valid_id,
  output logic [XLEN-1:0] ras_target_id
);

  localparam logic [31:0] I_NOP = 32'h0000_0013;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(MEM_LATENCY + 1);
  localparam int SUM_W = CNT_W + 1;

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("svc_rv_stage_if_mem: MEM_LATENCY must be 1..4");
  end
  if (FIFO_DEPTH < MEM_LATENCY + 1) begin : g_bad_depth
    $error("svc_rv_stage_if_mem: FIFO_DEPTH must be >= MEM_LATENCY+1");
  end

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            btb_hit;
    logic            btb_taken;
    logic [XLEN-1:0] btb_target;
    logic            ras_valid;
    logic [XLEN-1:0] ras_target;
  } sb_t;

  logic [MEM_LATENCY-1:0] vld_p;
  sb_t                    sb_p [MEM_LATENCY];
  sb_t                    sb_in;
  sb_t                    fifo_sb [FIFO_DEPTH];
  logic [31:0]            fifo_instr [FIFO_DEPTH];
  sb_t                    head;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [INF_W-1:0]       inflight;
  logic [SUM_W-1:0]       occ;
  logic                   head_vld, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) inflight = inflight + INF_W'(vld_p[i]);
  end

  // Credit: everything in flight or buffered, less what leaves this cycle, must fit.
  assign head_vld   = rst_n & (count != '0);
  assign pop        = head_vld & ~if_id_stall & ~if_id_flush;
  assign occ        = SUM_W'(inflight) + SUM_W'(count) - SUM_W'(pop);
  assign fetch_fire = rst_n & ~if_id_flush & (occ < SUM_W'(FIFO_DEPTH));
  assign push       = rst_n & ~if_id_flush & vld_p[MEM_LATENCY-1];
  assign imem_ren   = fetch_fire;

  if (XLEN >= 32) begin : g_raddr_trunc
    assign imem_raddr = pc[31:0];
  end else begin : g_raddr_ext
    assign imem_raddr = {{(32 - XLEN){1'b0}}, pc};
  end

  always_comb begin
    sb_in            = '0;
    sb_in.pc         = pc;
    sb_in.pc4        = pc + XLEN'(4);
    sb_in.btb_hit    = btb_hit_if;
    sb_in.btb_taken  = btb_pred_taken_if;
    sb_in.btb_target = btb_target_if;
    sb_in.ras_valid  = ras_valid_if;
    sb_in.ras_target = ras_target_if;
  end

  // Issue -> sideband pipe stages p0..p(LAT-1), aligned with the memory read latency
  always_ff @(posedge clk) begin
    if (!rst_n || if_id_flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= fetch_fire;
      for (int i = 1; i < MEM_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    sb_p[0] <= sb_in;
    for (int i = 1; i < MEM_LATENCY; i++) sb_p[i] <= sb_p[i-1];
  end

  // Return -> response FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_sb[wr_ptr]    <= sb_p[MEM_LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || if_id_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == CNT_W'(FIFO_DEPTH)));

  // FIFO head -> ID outputs; empty or reset presents a NOP with zeroed sideband
  assign head              = fifo_sb[rd_ptr];
  assign valid_id          = head_vld;
  assign instr_id          = head_vld ? fifo_instr[rd_ptr] : I_NOP;
  assign pc_id             = head_vld ? head.pc : '0;
  assign pc_plus4_id       = head_vld ? head.pc4 : '0;
  assign btb_hit_id        = head_vld & head.btb_hit;
  assign btb_pred_taken_id = head_vld & head.btb_taken;
  assign btb_target_id     = head_vld ? head.btb_target : '0;
  assign ras_valid_id      = head_vld & head.ras_valid;
  assign ras_target_id     = head_vld ? head.ras_target : '0;

endmodule

// File: tb/tb_svc_rv_stage_if_mem.sv
// Bench for svc_rv_stage_if_mem: three instances (latency 2, 1, 4) share stall/flush/reset;
// directed checks on the latency-2 instance plus a program-order scoreboard on all three.
module tb_svc_rv_stage_if_mem;

  localparam int N = 3;
  localparam int LATS [N] = '{2, 1, 4};
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n, stall, flush;
  logic [N-1:0][31:0] pc, btb_tgt, ras_tgt, rdata;
  logic [N-1:0]       btb_hit, btb_taken, ras_v;
  wire  [N-1:0][31:0] raddr, instr_id, pc_id, pc4_id, btb_tgt_id, ras_tgt_id;
  wire  [N-1:0]       fire, ren, valid_id, btb_hit_id, btb_taken_id, ras_v_id;

  logic [31:0] mem [N][4];
  logic [31:0] exp_q [N][2048];
  int wr_i [N];
  int rd_i [N];

  logic [N-1:0]       s_ff, s_v, s_ren, s_bh, s_rv;
  logic [N-1:0][31:0] s_pc, s_instr, s_raddr, s_pc4, s_bt, s_rt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    svc_rv_stage_if_mem #(.XLEN(32), .MEM_LATENCY(LATS[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .pc(pc[g]), .fetch_fire(fire[g]),
      .if_id_stall(stall), .if_id_flush(flush),
      .btb_hit_if(btb_hit[g]), .btb_pred_taken_if(btb_taken[g]), .btb_target_if(btb_tgt[g]),
      .ras_valid_if(ras_v[g]), .ras_target_if(ras_tgt[g]),
      .imem_ren(ren[g]), .imem_raddr(raddr[g]), .imem_rdata(rdata[g]),
      .instr_id(instr_id[g]), .valid_id(valid_id[g]), .pc_id(pc_id[g]), .pc_plus4_id(pc4_id[g]),
      .btb_hit_id(btb_hit_id[g]), .btb_pred_taken_id(btb_taken_id[g]), .btb_target_id(btb_tgt_id[g]),
      .ras_valid_id(ras_v_id[g]), .ras_target_id(ras_tgt_id[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, expv);
    end
  endtask

  function automatic string tg(input string name, input int i);
    return $sformatf("%s[L%0d]", name, LATS[i]);
  endfunction

  // One clock: drive sideband from pc, sample before the edge, score, then advance models.
  task automatic tick();
    logic [31:0] e;
    for (int i = 0; i < N; i++) begin
      btb_hit[i]   = (pc[i] == 32'h8);
      btb_taken[i] = btb_hit[i];
      btb_tgt[i]   = btb_hit[i] ? 32'h40 : 32'h0;
      ras_v[i]     = (pc[i] == 32'h100);
      ras_tgt[i]   = ras_v[i] ? 32'h1234 : 32'h0;
    end
    #2;
    for (int i = 0; i < N; i++) begin
      s_ff[i] = fire[i];   s_v[i] = valid_id[i];   s_ren[i] = ren[i];
      s_pc[i] = pc_id[i];  s_instr[i] = instr_id[i]; s_raddr[i] = raddr[i];
      s_pc4[i] = pc4_id[i]; s_bh[i] = btb_hit_id[i]; s_bt[i] = btb_tgt_id[i];
      s_rv[i] = ras_v_id[i]; s_rt[i] = ras_tgt_id[i];
      if (!rst_n) begin
        rd_i[i] = wr_i[i];
      end else if (flush) begin
        chk(tg("flush_fire", i), 32'(s_ff[i]), 32'd0);
        rd_i[i] = wr_i[i];
      end else begin
        if (s_v[i]) begin
          chk(tg("sb_occ", i), 32'(rd_i[i] < wr_i[i]), 32'd1);
          e = exp_q[i][rd_i[i] & 2047];
          chk(tg("pc_id", i), s_pc[i], e);
          chk(tg("instr_id", i), s_instr[i], e ^ 32'hC0DE_0000);
          chk(tg("pc_plus4_id", i), s_pc4[i], e + 32'd4);
          chk(tg("btb_hit_id", i), 32'(s_bh[i]), 32'(e == 32'h8));
          chk(tg("btb_target_id", i), s_bt[i], (e == 32'h8) ? 32'h40 : 32'h0);
          chk(tg("btb_taken_id", i), 32'(btb_taken_id[i]), 32'(e == 32'h8));
          chk(tg("ras_valid_id", i), 32'(s_rv[i]), 32'(e == 32'h100));
          chk(tg("ras_target_id", i), s_rt[i], (e == 32'h100) ? 32'h1234 : 32'h0);
          if (!stall) rd_i[i]++;
        end else begin
          chk(tg("idle_instr", i), s_instr[i], NOP);
        end
        if (s_ff[i]) begin
          chk(tg("imem_raddr", i), s_raddr[i], pc[i]);
          exp_q[i][wr_i[i] & 2047] = pc[i];
          wr_i[i]++;
        end
        chk(tg("imem_ren", i), 32'(s_ren[i]), 32'(s_ff[i]));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      for (int k = 3; k > 0; k--) mem[i][k] = mem[i][k-1];
      mem[i][0] = s_raddr[i] ^ 32'hC0DE_0000;
      rdata[i]  = mem[i][LATS[i]-1];
      if (s_ff[i]) pc[i] = pc[i] + 32'd4;
    end
  endtask

  initial begin
    logic [31:0] tgt;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      pc[i] = 32'h0; rdata[i] = 32'h0; wr_i[i] = 0; rd_i[i] = 0;
      for (int k = 0; k < 4; k++) mem[i][k] = 32'h0;
    end
    @(posedge clk);
    #1;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(s_v[0]), 32'd0);
    chk("rst_instr", s_instr[0], NOP);
    chk("rst_fire", 32'(s_ff[0]), 32'd0);
    chk("rst_ren", 32'(s_ren[0]), 32'd0);
    chk("rst_pc_id", s_pc[0], 32'h0);
    chk("rst_btb_target", s_bt[0], 32'h0);

    // Streaming: issue at c0, first visible at c3
    rst_n = 1'b1;
    tick(); chk("c0_fire", 32'(s_ff[0]), 32'd1);
    tick(); chk("c1_fire", 32'(s_ff[0]), 32'd1); chk("c1_valid", 32'(s_v[0]), 32'd0);
    tick(); chk("c2_fire", 32'(s_ff[0]), 32'd1); chk("c2_valid", 32'(s_v[0]), 32'd0);
    tick(); chk("c3_valid", 32'(s_v[0]), 32'd1); chk("c3_pc", s_pc[0], 32'h0);
    chk("c3_instr", s_instr[0], 32'hC0DE_0000); chk("c3_btb", 32'(s_bh[0]), 32'd0);
    tick(); chk("c4_pc", s_pc[0], 32'h4); chk("c4_fire", 32'(s_ff[0]), 32'd1);
    tick(); chk("c5_pc", s_pc[0], 32'h8); chk("c5_btb_hit", 32'(s_bh[0]), 32'd1);
    chk("c5_btb_tgt", s_bt[0], 32'h40);
    tick(); chk("c6_pc", s_pc[0], 32'hC); chk("c6_btb_hit", 32'(s_bh[0]), 32'd0);
    chk("c6_btb_tgt", s_bt[0], 32'h0);

    // Stall backpressure: credits are exhausted immediately at steady state
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("stall%0d_fire", c), 32'(s_ff[0]), 32'd0);
      chk($sformatf("stall%0d_valid", c), 32'(s_v[0]), 32'd1);
    end
    stall = 1'b0;
    tick(); chk("release_fire", 32'(s_ff[0]), 32'd1);
    tick(); chk("release1_fire", 32'(s_ff[0]), 32'd1);
    tick(); tick();

    // Flush with two in flight and one buffered
    flush = 1'b1;
    for (int i = 0; i < N; i++) pc[i] = 32'h100;
    tick(); chk("flush_cycle_fire", 32'(s_ff[0]), 32'd0);
    flush = 1'b0;
    tick(); chk("f1_valid", 32'(s_v[0]), 32'd0); chk("f1_fire", 32'(s_ff[0]), 32'd1);
    tick(); chk("f2_valid", 32'(s_v[0]), 32'd0);
    tick(); chk("f3_valid", 32'(s_v[0]), 32'd0);
    tick(); chk("f4_valid", 32'(s_v[0]), 32'd1); chk("f4_pc", s_pc[0], 32'h100);
    chk("f4_ras_v", 32'(s_rv[0]), 32'd1); chk("f4_ras_tgt", s_rt[0], 32'h1234);

    // Reset mid-stream with buffered and in-flight fetches
    tick(); tick();
    stall = 1'b1;
    tick(); tick();
    rst_n = 1'b0; stall = 1'b0;
    for (int i = 0; i < N; i++) pc[i] = 32'h200;
    tick(); chk("mrst_valid", 32'(s_v[0]), 32'd0); chk("mrst_instr", s_instr[0], NOP);
    chk("mrst_fire", 32'(s_ff[0]), 32'd0);
    rst_n = 1'b1;
    tick(); chk("prst_valid", 32'(s_v[0]), 32'd0); chk("prst_instr", s_instr[0], NOP);
    chk("prst_fire", 32'(s_ff[0]), 32'd1);
    tick(); tick();
    tick(); chk("prst_first_valid", 32'(s_v[0]), 32'd1); chk("prst_first_pc", s_pc[0], 32'h200);

    // Random stall/flush across all latencies, scoreboard checks order
    for (int c = 0; c < 300; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 29) == 0);
      if (flush) begin
        tgt = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
        for (int i = 0; i < N; i++) pc[i] = tgt;
      end
      tick();
    end

    // Unstalled throughput: one valid instruction per cycle on every instance
    stall = 1'b0; flush = 1'b0;
    repeat (8) tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < N; i++) chk(tg("rate_valid", i), 32'(s_v[i]), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/svc_rv_stage_if_mem.md
Name: svc_rv_stage_if_mem

Overview:
Instruction fetch stage for instruction memories with a fixed read latency of MEM_LATENCY cycles, such as BRAM or registered SRAM; this is the latency-parametrised successor of the zero-latency SRAM fetch stage.
It sits between the PC/prediction logic and the IF/ID register.
It issues one fetch per cycle when credit is available and carries PC, BTB and RAS sideband through a matched-latency pipe so they stay aligned with the returned instruction.
A response FIFO absorbs in-flight returns during stalls, and a flush kills every in-flight fetch.

Parameters:
XLEN, 32, PC/target width
MEM_LATENCY, 1, imem read latency in cycles; legal range 1..4
FIFO_DEPTH, MEM_LATENCY+1, response FIFO entries; must be >= MEM_LATENCY+1 (elaboration error otherwise)

Ports:
clk  in  1  clock
rst_n  in  1  reset
pc  in  XLEN  fetch address from PC logic
fetch_fire  out  1  fetch issued this cycle; PC logic advances only on this
if_id_stall  in  1  downstream stall; head not consumed
if_id_flush  in  1  redirect; kill in-flight and buffered fetches
btb_hit_if, btb_pred_taken_if  in  1 each  BTB prediction for pc
btb_target_if  in  XLEN  BTB target
ras_valid_if  in  1  RAS prediction valid
ras_target_if  in  XLEN  RAS target
imem_ren  out  1  read enable
imem_raddr  out  32  read address (= pc)
imem_rdata  in  32  data, valid MEM_LATENCY cycles after the ren cycle
instr_id  out  32  head instruction; I_NOP (0x00000013) when not valid
valid_id  out  1  head entry valid
pc_id, pc_plus4_id  out  XLEN each  head PC and PC+4
btb_hit_id, btb_pred_taken_id  out  1 each  aligned BTB sideband
btb_target_id  out  XLEN  aligned BTB target
ras_valid_id  out  1  aligned RAS sideband
ras_target_id  out  XLEN  aligned RAS target

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. In reset, FIFO empty, in-flight valid pipe cleared, valid_id=0, instr_id=I_NOP, all other *_id outputs 0, imem_ren=0, fetch_fire=0.
- Credit: inflight = number of set bits in the MEM_LATENCY-stage valid shift register; count = FIFO occupancy.
- Issue condition: fetch_fire = rst_n & !if_id_flush & (inflight + count - pop < FIFO_DEPTH).
- Issue outputs: imem_ren = fetch_fire; imem_raddr = pc (zero-extended or truncated to 32).
- Sideband pipe: on issue, stage 0 of the sideband pipe captures {valid=1, pc, pc+4 (XLEN wrap), btb_*, ras_*}.
- Sideband advance: the pipe shifts every cycle. A stage is loaded with valid=0 when no issue occurs.
- Return: when the last stage is valid, the entry is pushed into the FIFO with instr=imem_rdata sampled that cycle.
- Output: the FIFO head drives the *_id outputs combinationally from storage. Issue-to-visible latency is MEM_LATENCY+1 cycles.
- Pop: pop = valid_id & !if_id_stall & !if_id_flush. Push and pop in the same cycle are allowed, including when full or empty-then-push.
- Overflow: it cannot happen by the credit rule; an assertion checks for it.
- Stall: no pop. Issue continues until credits are exhausted, and in-flight data always lands in the FIFO. Sustained throughput is 1 instruction/cycle with no stall.
- Flush: FIFO cleared, all valid pipe bits cleared, any return arriving in the flush cycle is dropped, and no issue occurs in the flush cycle. The next cycle issues the redirected pc. valid_id=0 in the cycle after the flush.
- Simultaneous events: flush dominates stall, pop and push. Reset dominates everything.
- Reset mid-operation: same as flush plus output reset values; late imem_rdata returns are ignored.
- Pointer arithmetic: FIFO pointers wrap modulo FIFO_DEPTH (non-power-of-2 allowed). The count width is $clog2(FIFO_DEPTH+1).

Test Plan:
- Streaming: LAT=2, DEPTH=3, no stall, pc 0x0,0x4,0x8. Required: fetch_fire every cycle; valid_id first high 3 cycles after the first issue; pc_id 0x0,0x4,0x8 on consecutive cycles; instr_id matches the memory model.
- Stall backpressure: LAT=2, hold if_id_stall for 5 cycles mid-stream. Required: fetch_fire drops after credits hit 3; no instruction lost or duplicated; order preserved after release.
- Flush with in-flight: flush while 2 fetches are in flight and 1 is buffered, redirect pc=0x100. Required: none of the killed PCs appear; the next valid_id shows pc_id=0x100 with correct sideband.
- Sideband alignment: BTB hit and target 0x40 injected only for pc=0x8. Required: btb_hit_id=1 and btb_target_id=0x40 exactly when pc_id=0x8.
- Reset mid-stream: assert rst_n=0 with a full FIFO and in-flight fetches. Required: next cycle valid_id=0 and instr_id=0x00000013; post-reset first output is pc_id = the first pc after reset.
- Latency sweep: MEM_LATENCY=1 and 4 with default depth and random stall/flush. Required: the scoreboard matches program order, and the valid_id rate is 1/cycle when unstalled.
